// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand request channel
// and result channel, each with its own valid/ready pair.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first with a
// registered carry; result is offered on a valid/ready handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             s_bit;
  logic             cy_bit;

  assign s_bit  = a_q[0] ^ b_q[0] ^ cy_q;
  assign cy_bit = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          cy_d    = bus.c_in;
          sum_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        cy_d  = cy_bit;
        // Counter stops at WIDTH-1; the edge that sees it there is the last bit.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = cy_bit;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected
// {carry,sum} values pushed at accept and popped at each result handshake.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   results_seen;
  int   results_target;
  logic [WIDTH:0] exp_q[$];

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [WIDTH:0] exp_v;
    if (!rst) begin
      check_eq("excl_ready_valid", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("result", {23'd0, bus.carry_out, bus.sum_out}, {23'd0, exp_v});
          $display("txn %0d: carry=%0d sum=0x%02h (expected 0x%03h)",
                   results_seen, bus.carry_out, bus.sum_out, exp_v);
        end
        results_seen++;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input bit push);
    int k;
    logic [WIDTH:0] e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.c_in     = c;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      e = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      if (push) begin
        exp_q.push_back(e);
        results_target++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results();
    int k;
    k = 0;
    while (results_seen < results_target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("results_count", results_seen, results_target);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    int n;
    checks         = 0;
    errors         = 0;
    results_seen   = 0;
    results_target = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.a_in       = 8'h55;
    bus.b_in       = 8'h66;
    bus.c_in       = 1'b1;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sum", {24'd0, bus.sum_out}, 32'd0);
    check_eq("rst_carry", {31'd0, bus.carry_out}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Basic add with latency measurement
    send(8'h0F, 8'h01, 1'b0, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 50);
    check_eq("latency", n, WIDTH);
    wait_results();

    // Carry wrap cases
    send(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_results();
    send(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_results();

    // Backpressure in DONE
    bus.out_ready = 1'b0;
    send(8'h3C, 8'h42, 1'b0, 1'b1);
    wait_valid("bp_valid_rise");
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
      check_eq("bp_sum_held", {24'd0, bus.sum_out}, 32'h7E);
      check_eq("bp_carry_held", {31'd0, bus.carry_out}, 32'd0);
      check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_results();
    @(posedge clk); #1;
    check_eq("bp_released", {31'd0, bus.out_valid}, 32'd0);
    check_eq("bp_sum_kept", {24'd0, bus.sum_out}, 32'h7E);

    // in_valid during RUN must be ignored
    send(8'h01, 8'h02, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a_in     = 8'hAA;
    bus.b_in     = 8'h55;
    bus.c_in     = 1'b1;
    check_eq("run_busy", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_results();
    repeat (12) @(negedge clk);
    check_eq("no_capture_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("no_capture_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("no_capture_seen", results_seen, results_target);

    // Reset pulse mid-RUN aborts the transaction
    send(8'h11, 8'h22, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_sum", {24'd0, bus.sum_out}, 32'd0);
    check_eq("abort_carry", {31'd0, bus.carry_out}, 32'd0);
    check_eq("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h80, 8'h80, 1'b0, 1'b1);
    wait_results();

    // Random back-to-back traffic
    for (int i = 0; i < 100; i++) begin
      send(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1);
    end
    wait_results();
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
